// File: rtl/baby_ctrl_pkg.sv
// rtl/baby_ctrl_pkg.sv - shared state encoding, opcodes and strobe bundle for the Baby sequencer
package baby_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_INC,
        S_FADDR,
        S_FWAIT,
        S_FLATCH,
        S_DECODE,
        S_XPRE,
        S_RWAIT,
        S_RLATCH,
        S_XALU,
        S_WWAIT,
        S_WEND,
        S_CMP_SKIP,
        S_CMP_NOP,
        S_HALTED,
        S_FAULT
    } state_e;

    localparam logic [2:0] FUNC_JMP  = 3'd0;
    localparam logic [2:0] FUNC_JRP  = 3'd1;
    localparam logic [2:0] FUNC_LDN  = 3'd2;
    localparam logic [2:0] FUNC_STO  = 3'd3;
    localparam logic [2:0] FUNC_SUB  = 3'd4;
    localparam logic [2:0] FUNC_SUB2 = 3'd5;
    localparam logic [2:0] FUNC_CMP  = 3'd6;
    localparam logic [2:0] FUNC_STP  = 3'd7;

    localparam logic [1:0] ALU_NEG_B     = 2'b00;
    localparam logic [1:0] ALU_A_MINUS_B = 2'b01;
    localparam logic [1:0] ALU_A_PLUS_B  = 2'b10;

    typedef struct packed {
        logic       pc_clk;
        logic       pc_load_n;
        logic       pc_oe_n;
        logic       ir_load_n;
        logic       ir_oe_n;
        logic       mar_load_n;
        logic       mem_rd_n;
        logic       mem_wr_n;
        logic       acc_load_n;
        logic       acc_oe_n;
        logic       alu_a_load_n;
        logic       alu_b_load_n;
        logic [1:0] alu_op;
        logic       alu_oe_n;
        logic       halted;
        logic       fault;
    } strobes_t;

    localparam strobes_t STROBES_IDLE = '{
        pc_clk:       1'b0,
        pc_load_n:    1'b1,
        pc_oe_n:      1'b1,
        ir_load_n:    1'b1,
        ir_oe_n:      1'b1,
        mar_load_n:   1'b1,
        mem_rd_n:     1'b1,
        mem_wr_n:     1'b1,
        acc_load_n:   1'b1,
        acc_oe_n:     1'b1,
        alu_a_load_n: 1'b1,
        alu_b_load_n: 1'b1,
        alu_op:       ALU_NEG_B,
        alu_oe_n:     1'b1,
        halted:       1'b0,
        fault:        1'b0
    };

    function automatic logic is_wait(input state_e s);
        return (s == S_FWAIT) || (s == S_RWAIT) || (s == S_WWAIT);
    endfunction

    // Each state drives at most one bus source; func selects the operand/destination.
    function automatic strobes_t decode_strobes(input state_e s, input logic [2:0] func);
        strobes_t o;
        o = STROBES_IDLE;
        case (s)
            S_INC:      o.pc_clk = 1'b1;
            S_FADDR:    begin o.pc_oe_n = 1'b0; o.mar_load_n = 1'b0; end
            S_FWAIT,
            S_RWAIT:    o.mem_rd_n = 1'b0;
            S_FLATCH:   begin o.mem_rd_n = 1'b0; o.ir_load_n = 1'b0; end
            S_DECODE:   begin o.ir_oe_n = 1'b0; o.mar_load_n = 1'b0; end
            S_XPRE: begin
                o.alu_a_load_n = 1'b0;
                if (func == FUNC_JRP) o.pc_oe_n  = 1'b0;
                else                  o.acc_oe_n = 1'b0;
            end
            S_RLATCH: begin
                o.mem_rd_n = 1'b0;
                if (func == FUNC_JMP) o.pc_load_n    = 1'b0;
                else                  o.alu_b_load_n = 1'b0;
            end
            S_XALU: begin
                o.alu_oe_n = 1'b0;
                case (func)
                    FUNC_JRP: begin o.alu_op = ALU_A_PLUS_B;  o.pc_load_n  = 1'b0; end
                    FUNC_LDN: begin o.alu_op = ALU_NEG_B;     o.acc_load_n = 1'b0; end
                    default:  begin o.alu_op = ALU_A_MINUS_B; o.acc_load_n = 1'b0; end
                endcase
            end
            S_WWAIT:    begin o.acc_oe_n = 1'b0; o.mem_wr_n = 1'b0; end
            S_WEND:     o.acc_oe_n = 1'b0;
            S_CMP_SKIP: o.pc_clk = 1'b1;
            S_HALTED:   o.halted = 1'b1;
            S_FAULT:    o.fault = 1'b1;
            default:    ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/baby_ready_timer.sv
// rtl/baby_ready_timer.sv - reloadable down-counter flagging a store that never raises ready
module baby_ready_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic load_i,
    input  logic count_i,
    output logic expired_o
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LOAD_VAL = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = LOAD_VAL;
        else if (count_i && (cnt_q != '0))
            cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) cnt_q <= LOAD_VAL;
        else         cnt_q <= cnt_d;
    end

    // Fires on the TIMEOUT-th consecutive not-ready wait cycle.
    assign expired_o = (TIMEOUT != 0) && count_i && (cnt_q == '0);

endmodule

// File: rtl/baby_control_sequencer.sv
// rtl/baby_control_sequencer.sv - Moore fetch/decode/execute sequencer for the Baby datapath
module baby_control_sequencer
    import baby_ctrl_pkg::*;
#(
    parameter int READY_TIMEOUT = 255
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic       STOP,
    input  logic       MEM_READY,
    input  logic [2:0] IR_FUNC,
    input  logic       ACC_NEG,
    output logic       PC_CLK,
    output logic       PC_LOAD_n,
    output logic       PC_OE_n,
    output logic       IR_LOAD_n,
    output logic       IR_OE_n,
    output logic       MAR_LOAD_n,
    output logic       MEM_RD_n,
    output logic       MEM_WR_n,
    output logic       ACC_LOAD_n,
    output logic       ACC_OE_n,
    output logic       ALU_A_LOAD_n,
    output logic       ALU_B_LOAD_n,
    output logic [1:0] ALU_OP,
    output logic       ALU_OE_n,
    output logic       HALTED,
    output logic       FAULT
);

    state_e     state_q, state_d;
    logic [2:0] func_q, func_d;
    logic       stop_q, stop_d;
    strobes_t   out_q;
    logic       timeout;
    logic       running;
    state_e     boundary;

    baby_ready_timer #(.TIMEOUT(READY_TIMEOUT)) u_ready_timer (
        .clk_i     (CLK),
        .reset_i   (RESET),
        .load_i    (!is_wait(state_q)),
        .count_i   (is_wait(state_q) && !MEM_READY),
        .expired_o (timeout)
    );

    always_comb begin
        state_d  = state_q;
        func_d   = func_q;
        running  = (state_q != S_IDLE) && (state_q != S_HALTED) && (state_q != S_FAULT);
        boundary = (stop_q || STOP) ? S_HALTED : S_INC;
        case (state_q)
            S_IDLE,
            S_HALTED:   if (START && !STOP) state_d = S_INC;
            S_INC:      state_d = S_FADDR;
            S_FADDR:    state_d = S_FWAIT;
            S_FWAIT:    if (MEM_READY) state_d = S_FLATCH;
                        else if (timeout) state_d = S_FAULT;
            S_FLATCH:   state_d = S_DECODE;
            S_DECODE: begin
                func_d = IR_FUNC;
                case (IR_FUNC)
                    FUNC_JMP, FUNC_LDN:            state_d = S_RWAIT;
                    FUNC_JRP, FUNC_SUB, FUNC_SUB2: state_d = S_XPRE;
                    FUNC_STO:                      state_d = S_WWAIT;
                    FUNC_CMP:                      state_d = ACC_NEG ? S_CMP_SKIP : S_CMP_NOP;
                    default:                       state_d = S_HALTED;
                endcase
            end
            S_XPRE:     state_d = S_RWAIT;
            S_RWAIT:    if (MEM_READY) state_d = S_RLATCH;
                        else if (timeout) state_d = S_FAULT;
            S_RLATCH:   state_d = (func_q == FUNC_JMP) ? boundary : S_XALU;
            S_WWAIT:    if (MEM_READY) state_d = S_WEND;
                        else if (timeout) state_d = S_FAULT;
            S_XALU,
            S_WEND,
            S_CMP_SKIP,
            S_CMP_NOP:  state_d = boundary;
            S_FAULT:    state_d = S_FAULT;
            default:    state_d = S_IDLE;
        endcase
        // STOP is remembered until the next instruction boundary takes us to HALTED.
        stop_d = (state_d == S_HALTED) ? 1'b0 : (stop_q || (running && STOP));
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            func_q  <= FUNC_JMP;
            stop_q  <= 1'b0;
            out_q   <= STROBES_IDLE;
        end else begin
            state_q <= state_d;
            func_q  <= func_d;
            stop_q  <= stop_d;
            out_q   <= decode_strobes(state_d, func_d);
        end
    end

    assign PC_CLK       = out_q.pc_clk;
    assign PC_LOAD_n    = out_q.pc_load_n;
    assign PC_OE_n      = out_q.pc_oe_n;
    assign IR_LOAD_n    = out_q.ir_load_n;
    assign IR_OE_n      = out_q.ir_oe_n;
    assign MAR_LOAD_n   = out_q.mar_load_n;
    assign MEM_RD_n     = out_q.mem_rd_n;
    assign MEM_WR_n     = out_q.mem_wr_n;
    assign ACC_LOAD_n   = out_q.acc_load_n;
    assign ACC_OE_n     = out_q.acc_oe_n;
    assign ALU_A_LOAD_n = out_q.alu_a_load_n;
    assign ALU_B_LOAD_n = out_q.alu_b_load_n;
    assign ALU_OP       = out_q.alu_op;
    assign ALU_OE_n     = out_q.alu_oe_n;
    assign HALTED       = out_q.halted;
    assign FAULT        = out_q.fault;

endmodule
